// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: decodes the M-stage access, runs a single-outstanding
// request/grant bus transaction, and returns the aligned, extended load data.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [1:0]  MemSizeM,
    input  logic [2:0]  funct3M,
    input  logic        HoldM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignedM,
    output logic        BusErrM
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]      data_q, data_d;
    logic             buserr_q, buserr_d;

    logic        is_store, is_load, is_op, is_byte, is_half, is_word, mis;
    logic        timeout, req_c;
    logic [1:0]  off;
    logic [31:0] shifted, load_ext;
    logic [15:0] half_sel;

    always_comb begin
        off      = ALUResultM[1:0];
        is_store = MemWriteM;
        is_load  = !MemWriteM && (ResultSrcM == 2'b01);
        is_op    = is_store || is_load;
        is_byte  = (MemSizeM == 2'b00);
        is_half  = (MemSizeM == 2'b01);
        is_word  = MemSizeM[1];
        mis      = is_op && ((is_half && ALUResultM[0]) || (is_word && (off != 2'b00)));
    end

    // Bus-side formatting: stores replicate the low lanes so any enabled byte sees its data.
    always_comb begin
        mem_addr = {ALUResultM[31:2], 2'b00};
        mem_we   = is_store;
        if (is_byte) begin
            mem_be    = 4'b0001 << off;
            mem_wdata = {4{WriteDataM[7:0]}};
        end else if (is_half) begin
            mem_be    = 4'b0011 << {off[1], 1'b0};
            mem_wdata = {2{WriteDataM[15:0]}};
        end else begin
            mem_be    = 4'b1111;
            mem_wdata = WriteDataM;
        end
    end

    always_comb begin
        shifted  = mem_rdata >> {off, 3'b000};
        half_sel = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (is_byte)
            load_ext = funct3M[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        else if (is_half)
            load_ext = funct3M[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        else
            load_ext = mem_rdata;
    end

    always_comb begin
        cnt_inc = cnt_q + CNT_W'(1);
        timeout = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIMIT);
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        buserr_d = 1'b0;
        req_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_op && !mis) begin
                    req_c = 1'b1;
                    cnt_d = '0;
                    if (mem_gnt) state_d = is_store ? DONE : WAIT;
                    else         state_d = REQ;
                end
            end
            REQ: begin
                req_c = 1'b1;
                cnt_d = cnt_inc;
                if (mem_gnt) begin
                    state_d = is_store ? DONE : WAIT;
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d  = DONE;
                    data_d   = '0;
                    buserr_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (mem_rvalid) begin
                    state_d = DONE;
                    data_d  = load_ext;
                end else if (timeout) begin
                    state_d  = DONE;
                    data_d   = '0;
                    buserr_d = 1'b1;
                end
            end
            DONE: begin
                buserr_d = buserr_q;
                if (!HoldM) begin
                    state_d  = IDLE;
                    buserr_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset gates the combinational handshake so an in-flight access is dropped at once.
    always_comb begin
        mem_req     = !reset && req_c;
        StallM      = !reset && is_op && !mis && (state_q != DONE);
        MisalignedM = mis && (state_q == IDLE);
        ReadDataM   = data_q;
        BusErrM     = buserr_q;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            buserr_q <= buserr_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized accesses
// compared against an arithmetic reference model of the load/store formatting.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResultM, WriteDataM, mem_addr, mem_wdata, mem_rdata, ReadDataM;
    logic        MemWriteM, HoldM, mem_req, mem_we, mem_gnt, mem_rvalid;
    logic        StallM, MisalignedM, BusErrM;
    logic [1:0]  ResultSrcM, MemSizeM;
    logic [2:0]  funct3M;
    logic [3:0]  mem_be;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_data = 32'h0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .MemSizeM(MemSizeM), .funct3M(funct3M), .HoldM(HoldM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ReadDataM(ReadDataM), .StallM(StallM), .MisalignedM(MisalignedM), .BusErrM(BusErrM)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                               input logic [31:0] addr, input logic [31:0] rd);
        longint v;
        int     sh;
        if (sz == 2'd0) begin
            sh = 8 * int'(addr[1:0]);
            v  = longint'(rd >> sh) & 64'd255;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            sh = 16 * int'(addr[1]);
            v  = longint'(rd >> sh) & 64'd65535;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(rd);
        end
        return 32'(v);
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] addr);
        if (sz == 2'd0) return 4'(1 << int'(addr[1:0]));
        if (sz == 2'd1) return 4'(3 << (2 * int'(addr[1])));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return 32'(wd[7:0]) * 32'h0101_0101;
        if (sz == 2'd1) return 32'(wd[15:0]) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic drive_nop();
        MemWriteM  = 1'b0;
        ResultSrcM = ($urandom % 2 == 0) ? 2'b00 : 2'b10;
        HoldM      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'($urandom % 2);
        mem_rdata  = $urandom;
    endtask

    // One complete access, entered and left just after a rising edge.
    // g = cycles before grant, k = extra WAIT cycles before rvalid, hold = extra DONE cycles.
    task automatic do_access(input bit st, input logic [1:0] sz, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                             input int g, input int k, input int hold, input string tag);
        int          stall;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        stall      = st ? g + 1 : g + k + 2;
        ebe        = model_be(sz, addr);
        ewd        = model_wdata(sz, wd);
        if (!st) exp_data = model_load(sz, uns, addr, rd);
        MemWriteM  = st;
        ResultSrcM = st ? 2'($urandom) : 2'b01;
        MemSizeM   = sz;
        funct3M    = {uns, 2'($urandom)};
        ALUResultM = addr;
        WriteDataM = wd;
        HoldM      = 1'b0;
        for (int c = 0; c <= stall; c++) begin
            mem_gnt    = (c == g);
            mem_rvalid = (!st && c == g + 1 + k) ||
                         ((st || c <= g || c == stall) && ($urandom % 2 == 1));
            mem_rdata  = (!st && c == g + 1 + k) ? rd : $urandom;
            HoldM      = (c == stall) && (hold > 0);
            #4;
            n_vec++;
            if (StallM !== (c < stall)) begin
                n_err++;
                $display("FAIL %s StallM c=%0d: got %b expected %b", tag, c, StallM, c < stall);
            end
            n_vec++;
            if (mem_req !== (c <= g)) begin
                n_err++;
                $display("FAIL %s mem_req c=%0d: got %b expected %b", tag, c, mem_req, c <= g);
            end
            if (c <= g) begin
                n_vec++;
                if (mem_be !== ebe || mem_wdata !== ewd || mem_we !== st ||
                    mem_addr !== {addr[31:2], 2'b00}) begin
                    n_err++;
                    $display("FAIL %s bus c=%0d: got be=%h wd=%h we=%b a=%h expected be=%h wd=%h we=%b a=%h",
                             tag, c, mem_be, mem_wdata, mem_we, mem_addr, ebe, ewd, st,
                             {addr[31:2], 2'b00});
                end
            end
            if (c == stall) begin
                n_vec++;
                if (ReadDataM !== exp_data || BusErrM !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s done: got rd=%h berr=%b expected rd=%h berr=0",
                             tag, ReadDataM, BusErrM, exp_data);
                end
            end
            @(posedge clk); #1;
        end
        for (int h = 0; h < hold; h++) begin
            HoldM      = (h < hold - 1);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            #4;
            n_vec++;
            if (StallM !== 1'b0 || mem_req !== 1'b0 || ReadDataM !== exp_data) begin
                n_err++;
                $display("FAIL %s hold h=%0d: got stall=%b req=%b rd=%h expected 0 0 %h",
                         tag, h, StallM, mem_req, ReadDataM, exp_data);
            end
            @(posedge clk); #1;
        end
        drive_nop();
        #4;
        n_vec++;
        if (StallM !== 1'b0 || mem_req !== 1'b0 || ReadDataM !== exp_data) begin
            n_err++;
            $display("FAIL %s idle: got stall=%b req=%b rd=%h expected 0 0 %h",
                     tag, StallM, mem_req, ReadDataM, exp_data);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive_nop();
        MemSizeM = 2'b10; funct3M = 3'b0; ALUResultM = 32'h0; WriteDataM = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (mem_req !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0 ||
            BusErrM !== 1'b0 || MisalignedM !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got req=%b stall=%b rd=%h berr=%b mis=%b expected all 0",
                     mem_req, StallM, ReadDataM, BusErrM, MisalignedM);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw_basic();
        do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, "lw_basic");
    endtask

    task automatic test_lb_lbu();
        do_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0, "lb");
        n_vec++;
        if (exp_data !== 32'hFFFF_FF80 || ReadDataM !== 32'hFFFF_FF80) begin
            n_err++;
            $display("FAIL lb value: got %h expected ffffff80", ReadDataM);
        end
        do_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_0000, 1, 1, 0, "lbu");
        n_vec++;
        if (ReadDataM !== 32'h0000_0080) begin
            n_err++;
            $display("FAIL lbu value: got %h expected 00000080", ReadDataM);
        end
    endtask

    task automatic test_sh_delayed();
        do_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_ABCD, 32'h0, 3, 0, 0, "sh_delayed");
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [2] = '{32'h102, 32'h101};
        logic [1:0]  sizes [2] = '{2'b10, 2'b01};
        for (int i = 0; i < 2; i++) begin
            MemWriteM  = 1'b0;
            ResultSrcM = 2'b01;
            MemSizeM   = sizes[i];
            ALUResultM = addrs[i];
            mem_gnt    = 1'b1;
            for (int c = 0; c < 2; c++) begin
                #4;
                n_vec++;
                if (MisalignedM !== 1'b1 || mem_req !== 1'b0 || StallM !== 1'b0) begin
                    n_err++;
                    $display("FAIL misaligned %0d c=%0d: got mis=%b req=%b stall=%b expected 1 0 0",
                             i, c, MisalignedM, mem_req, StallM);
                end
                @(posedge clk); #1;
            end
            drive_nop();
            @(posedge clk); #1;
        end
        do_access(1'b1, 2'b11, 1'b0, 32'h300, 32'hCAFE_F00D, 32'h0, 0, 0, 0, "after_mis");
    endtask

    task automatic test_hold();
        do_access(1'b0, 2'b01, 1'b0, 32'h402, 32'h0, 32'h9ABC_1234, 0, 1, 3, "hold_lh");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bit          st;
            logic [1:0]  sz;
            logic [31:0] addr;
            st   = 1'($urandom);
            sz   = 2'($urandom);
            addr = $urandom & 32'hFFFF_FFFC;
            if (sz == 2'b00) addr[1:0] = 2'($urandom);
            if (sz == 2'b01) addr[1]   = 1'($urandom);
            do_access(st, sz, 1'($urandom), addr, $urandom, $urandom,
                      int'($urandom % 4), int'($urandom % 3), int'($urandom % 3), "random");
        end
    endtask

    task automatic test_timeout();
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b01;
        MemSizeM   = 2'b10;
        ALUResultM = 32'h500;
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #4;
            n_vec++;
            if (StallM !== 1'b1 || mem_req !== (c == 0) || BusErrM !== 1'b0) begin
                n_err++;
                $display("FAIL timeout wait c=%0d: got stall=%b req=%b berr=%b expected 1 %b 0",
                         c, StallM, mem_req, BusErrM, c == 0);
            end
            @(posedge clk); #1;
            mem_gnt = 1'b0;
        end
        exp_data = 32'h0;
        for (int c = 0; c < 3; c++) begin
            HoldM      = (c < 2);
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h5555_AAAA;
            #4;
            n_vec++;
            if (BusErrM !== 1'b1 || ReadDataM !== 32'h0 || StallM !== 1'b0 || mem_req !== 1'b0) begin
                n_err++;
                $display("FAIL timeout done c=%0d: got berr=%b rd=%h stall=%b req=%b expected 1 0 0 0",
                         c, BusErrM, ReadDataM, StallM, mem_req);
            end
            @(posedge clk); #1;
        end
        drive_nop();
        #4;
        n_vec++;
        if (BusErrM !== 1'b0 || ReadDataM !== 32'h0 || StallM !== 1'b0) begin
            n_err++;
            $display("FAIL timeout exit: got berr=%b rd=%h stall=%b expected 0 0 0",
                     BusErrM, ReadDataM, StallM);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b01;
        MemSizeM   = 2'b10;
        ALUResultM = 32'h600;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b0;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        n_vec++;
        if (StallM !== 1'b1 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid pre: got stall=%b req=%b expected 1 0", StallM, mem_req);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (mem_req !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid abort: got req=%b stall=%b rd=%h expected 0 0 0",
                     mem_req, StallM, ReadDataM);
        end
        #1;
        reset = 1'b0;
        #1;
        n_vec++;
        if (mem_req !== 1'b1 || StallM !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid idle: got req=%b stall=%b expected 1 1", mem_req, StallM);
        end
        exp_data = 32'h0;
        drive_nop();
        @(posedge clk); #1;
        do_access(1'b0, 2'b01, 1'b1, 32'h702, 32'h0, 32'hF00D_8001, 2, 2, 1, "post_reset");
    endtask

    initial begin
        test_reset();
        test_lw_basic();
        test_lb_lbu();
        test_sh_delayed();
        test_misaligned();
        test_hold();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit, directly downstream of the EX/MEM pipeline register.
- Consumes the M-stage ALU address, store data, size and signedness fields.
- Drives a single-outstanding request/grant data-memory bus and returns the aligned, extended load result to the MEM/WB register.
- Holds the pipeline with StallM while an access is in flight.

Parameters:
- TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before the access aborts with BusErrM; 0 disables the timeout.
- CNT_W, 16, width of the timeout counter; TIMEOUT_CYCLES must be < 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, low-aligned
- MemWriteM  in  1  store
- ResultSrcM  in  2  2'b01 = load
- MemSizeM  in  2  00 byte, 01 half, 10 word, 11 treated as word
- funct3M  in  3  bit2 = unsigned load (LBU/LHU)
- HoldM  in  1  external stall from hazard unit
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  {ALUResultM[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- ReadDataM  out  32  extended load result
- StallM  out  1  freeze IF..M stages
- MisalignedM  out  1  misaligned access detected
- BusErrM  out  1  access timed out

Behaviour:
- Op decode:
  - store = MemWriteM.
  - load = !MemWriteM & ResultSrcM==2'b01.
  - op = store | load.
- Misaligned decode:
  - mis = op & ((half & ALUResultM[0]) | (word & ALUResultM[1:0]!=0)).
  - MisalignedM = mis & state==IDLE, combinational.
  - A misaligned op issues no request and raises no stall.
- FSM states: IDLE, REQ, WAIT, DONE. Reset puts the FSM in IDLE.
- mem_req = (IDLE & op & !mis) | REQ. It is combinational, so a grant can arrive in the first cycle.
- IDLE:
  - op & !mis & mem_gnt: store -> DONE; load -> WAIT.
  - op & !mis & !mem_gnt -> REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_gnt: store -> DONE; load -> WAIT.
  - The request stays asserted with stable addr, we, be and wdata until granted.
- WAIT:
  - mem_rvalid -> DONE, capturing the extended data into the data register.
  - mem_rvalid is ignored in every other state.
- DONE:
  - StallM=0; ReadDataM presents the data register.
  - !HoldM -> IDLE; HoldM -> stay in DONE.
- StallM = op & !mis & state!=DONE, combinational.
- Latency:
  - Zero-wait store: 1 stall cycle.
  - Load with gnt in the first cycle and rvalid one cycle later: 2 stall cycles, data on the 3rd cycle.
- mem_be:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1],1'b0}.
  - word: 4'b1111.
- mem_wdata:
  - byte: {4{WriteDataM[7:0]}}.
  - half: {2{WriteDataM[15:0]}}.
  - word: WriteDataM.
- mem_we = store.
- Load extract:
  - Select the lane from mem_rdata >> (8*addr[1:0]) for byte, or by addr[1] for half.
  - Zero-extend if funct3M[2], otherwise sign-extend. Word passes through.
  - M-stage inputs are stable while StallM=1, so extraction uses the live address.
- Timeout counter:
  - Clears on entry to REQ or WAIT and increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES forces DONE, drops mem_req, sets the data register to 0 and raises BusErrM.
  - BusErrM is registered and high only while in DONE for that access.
  - A late rvalid is ignored.
- Reset values:
  - mem_req=0, ReadDataM=0, StallM=0, BusErrM=0, counter=0, state IDLE.
  - Reset mid-access aborts immediately; mem_req drops in the same cycle.
- Non-memory ops in IDLE: no request, StallM=0, ReadDataM holds its last value.

Test Plan:
- LW, addr 0x100, gnt in cycle 0, rvalid cycle 1, rdata 0xDEADBEEF -> StallM high 2 cycles, ReadDataM=0xDEADBEEF in DONE, mem_be=4'b1111.
- LB at addr 0x103 with rdata 0x80FF_0000 -> ReadDataM=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH, addr 0x202, data 0x1234ABCD, gnt delayed 3 cycles -> mem_req held 4 cycles, mem_be=4'b1100, mem_wdata=0xABCDABCD, StallM=1 for 4 cycles.
- LW at addr 0x102 -> MisalignedM=1, mem_req=0, StallM=0. LH at 0x101 -> same response.
- TIMEOUT_CYCLES=4, load granted, rvalid never arrives -> BusErrM=1 in DONE after 4 WAIT cycles, ReadDataM=0. An rvalid arriving afterwards causes no state change.
- Reset asserted in WAIT -> mem_req=0 and StallM=0 immediately, state IDLE. With HoldM=1 in DONE, the FSM stays in DONE and ReadDataM stays stable.
